spi_slave_responder18: RTL and testbench
========================================

Name: spi_slave_responder18

Overview:
- SPI slave endpoint that answers the SoC SPI master: the MISO-driving end of the link whose master outputs are sig_sclk_out18, sig_n_ss_out18 and sig_mo18.
- Oversamples sclk_in18, n_ss_in18 and si18 on the APB clock.
- Deserialises MOSI words into a parallel receive port.
- Serialises words from a valid/ready transmit port onto MISO.
- Supports all four CPOL/CPHA modes.

Parameters:
- DW, 8: word width in bits; legal range 4..32.
- SYNC_STAGES, 2: synchroniser depth on sclk_in18, n_ss_in18 and si18; minimum 2.

Ports:
- pclk18  in  1  APB clock; all logic is on its rising edge.
- n_p_reset18  in  1  asynchronous, active-low reset.
- cpol18  in  1  SCLK idle level; static while n_ss_in18 is low.
- cpha18  in  1  0 = sample on leading edge, 1 = sample on trailing edge; static while n_ss_in18 is low.
- sclk_in18  in  1  SPI clock from master.
- n_ss_in18  in  1  slave select, active low.
- si18  in  1  MOSI.
- so18  out  1  MISO data.
- n_so_en18  out  1  MISO output enable, active low.
- tx_data18  in  DW  word to transmit.
- tx_valid18  in  1  tx_data18 valid.
- tx_ready18  out  1  holding register empty.
- rx_data18  out  DW  last complete received word.
- rx_valid18  out  1  one-cycle pulse; rx_data18 is new.
- tx_underrun18  out  1  one-cycle pulse; word started with the holding register empty.
- frame_abort18  out  1  one-cycle pulse; n_ss_in18 rose mid-word.

Behaviour:
- Clock and reset: single clock pclk18. Reset is asynchronous and active-low on n_p_reset18, with synchronous deassertion handled by the SoC.
- Reset values: so18=0, n_so_en18=1, tx_ready18=1, rx_data18=0, rx_valid18=0, tx_underrun18=0, frame_abort18=0. Reset also clears the FSM to IDLE, the bit counter, both shift registers and the holding register.
- Synchronisers: all three SPI inputs pass through SYNC_STAGES flops. Edge detect compares the last two synchronised samples, so total input latency is SYNC_STAGES+1 pclk.
- Clock ratio: each SCLK phase must be at least 3 pclk. Faster SCLK is out of scope and is not checked.
- Leading edge: the SCLK transition away from cpol18. Trailing edge: the transition back to cpol18.
- Holding register: loaded when tx_valid18 && tx_ready18; tx_ready18 drops the next cycle. The register empties when its word moves into the TX shift register, and tx_ready18 rises the following cycle.
- FSM: IDLE -> LOAD -> SHIFT -> IDLE.
- IDLE:
  - n_so_en18=1 and so18 holds its last value.
  - A synchronised n_ss_in18 fall moves to LOAD.
- LOAD (exactly 1 cycle):
  - TX shift register <= holding register if full.
  - If empty, shift register <= all ones and tx_underrun18 pulses.
  - Bit counter <= 0, n_so_en18 <= 0, then -> SHIFT.
  - With cpha18=0, so18 presents bit DW-1 from this cycle.
- SHIFT, sample edge (leading if cpha18=0, trailing if cpha18=1):
  - RX shift register <= {rx_sr[DW-2:0], si_sync}.
  - Bit counter increments.
- SHIFT, drive edge (the other edge):
  - so18 <= next TX bit.
  - With cpha18=1 the first leading edge drives bit DW-1.
  - With cpha18=0 the trailing edge after the final sample of a word does not shift.
- Word complete (counter reaches DW on a sample edge):
  - rx_data18 <= received word and rx_valid18 pulses the next cycle.
  - Counter resets and the next TX word loads as in LOAD, with no extra cycle.
  - Back-to-back words continue without deasserting n_ss_in18.
- rx_valid18 has no backpressure; the consumer must take rx_data18 before the next word completes.
- n_ss_in18 rise in SHIFT:
  - Counter != 0: partial RX is discarded, no rx_valid18, frame_abort18 pulses, and the partially sent TX word is dropped.
  - Counter == 0: clean end, no pulse.
  - In both cases n_so_en18 <= 1 and the FSM -> IDLE.
- Simultaneous events:
  - tx_valid18 in the same cycle as a load from an empty holding register: the new word is accepted into the holding register and is not used for the current word. The underrun still fires.
  - n_ss_in18 rise coincident with the last sample edge: the sample edge completes the word (rx_valid18 pulses) and no abort is raised.
- Asynchronous reset mid-word: outputs go to their reset values immediately; the partial word and the holding register are lost.

Optional Feature:
- Macro: SPI_SLAVE_LSB_FIRST_EN.
- Defined: both directions are LSB-first.
  - TX sends bit 0 first and shifts right.
  - RX shifts in at bit DW-1 and shifts right.
  - Underrun fill is still all ones.
- Undefined: MSB-first only, as described above.

Test Plan:
1. Mode 0, DW=8: preload tx 0xA5; master sends 0x3C -> so18 sequence 1,0,1,0,0,1,0,1; rx_data18=0x3C with one rx_valid18 pulse; tx_ready18 back to 1.
2. Modes 1/2/3: same exchange with cpol/cpha = 01, 10, 11 -> identical data on both sides; so18 changes only on the drive edge, checked by a sample-edge stability assertion.
3. Back-to-back: tx 0x11 then 0x22, with 0x22 supplied mid-first-word; master sends 0x81,0x42 under one n_ss_in18 low -> two rx_valid18 pulses, values 0x81 then 0x42; MISO 0x11,0x22; no underrun.
4. Underrun: no tx_valid18; master sends 0x00 -> so18 all ones (0xFF), tx_underrun18 pulses once, rx_data18=0x00.
5. Abort: n_ss_in18 rises after 5 bits -> frame_abort18 pulse; no rx_valid18; n_so_en18=1 within SYNC_STAGES+2 pclk; next full frame 0x5A is received correctly.
6. Reset mid-word: assert n_p_reset18 after 3 bits -> n_so_en18=1, tx_ready18=1, rx_data18=0 asynchronously; the following frame works.

Source files
------------

// File: rtl/spi_slave_responder18.sv
// rtl/spi_slave_responder18.sv - SPI slave responder, all CPOL/CPHA modes; define SPI_SLAVE_LSB_FIRST_EN for LSB-first
module spi_slave_responder18 #(
   parameter int DW          = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic          pclk18,
   input  logic          n_p_reset18,
   input  logic          cpol18,
   input  logic          cpha18,
   input  logic          sclk_in18,
   input  logic          n_ss_in18,
   input  logic          si18,
   output logic          so18,
   output logic          n_so_en18,
   input  logic [DW-1:0] tx_data18,
   input  logic          tx_valid18,
   output logic          tx_ready18,
   output logic [DW-1:0] rx_data18,
   output logic          rx_valid18,
   output logic          tx_underrun18,
   output logic          frame_abort18
);

   localparam int CW = $clog2(DW + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
   state_t state, state_next;

   logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, si_sync;
   logic sclk_s, ss_s, si_s;
   logic sclk_prev, ss_prev;
   logic lead_edge, trail_edge, sample_edge, drive_edge, ss_fall;

   logic [DW-1:0] hold_reg, tx_sr, rx_sr;
   logic          hold_full;
   logic [CW-1:0] bit_cnt;
   logic          underrun_pend;

   logic          do_load, first_load, do_sample, do_drive, word_done, end_frame, abort;

   logic [DW-1:0] load_word, load_shifted, tx_sr_shifted, rx_sr_next;
   logic          load_bit, tx_out_bit;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign si_s   = si_sync[SYNC_STAGES-1];

   assign lead_edge   = (sclk_s != cpol18) && (sclk_prev == cpol18);
   assign trail_edge  = (sclk_s == cpol18) && (sclk_prev != cpol18);
   assign sample_edge = cpha18 ? trail_edge : lead_edge;
   assign drive_edge  = cpha18 ? lead_edge : trail_edge;
   assign ss_fall     = ss_prev && !ss_s;

   assign tx_ready18 = !hold_full;
   // An empty holding register sends all ones in either bit order.
   assign load_word  = hold_full ? hold_reg : {DW{1'b1}};

`ifdef SPI_SLAVE_LSB_FIRST_EN
   assign load_bit      = load_word[0];
   assign load_shifted  = {1'b0, load_word[DW-1:1]};
   assign tx_out_bit    = tx_sr[0];
   assign tx_sr_shifted = {1'b0, tx_sr[DW-1:1]};
   assign rx_sr_next    = {si_s, rx_sr[DW-1:1]};
`else
   assign load_bit      = load_word[DW-1];
   assign load_shifted  = {load_word[DW-2:0], 1'b0};
   assign tx_out_bit    = tx_sr[DW-1];
   assign tx_sr_shifted = {tx_sr[DW-2:0], 1'b0};
   assign rx_sr_next    = {rx_sr[DW-2:0], si_s};
`endif

   // Input synchronisers plus one extra stage per line for edge detection.
   always_ff @(posedge pclk18 or negedge n_p_reset18) begin
      if (!n_p_reset18) begin
         sclk_sync <= '0;
         ss_sync   <= '1;
         si_sync   <= '0;
         sclk_prev <= 1'b0;
         ss_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in18};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], n_ss_in18};
         si_sync   <= {si_sync[SYNC_STAGES-2:0], si18};
         sclk_prev <= sclk_s;
         ss_prev   <= ss_s;
      end
   end

   // FSM state register.
   always_ff @(posedge pclk18 or negedge n_p_reset18) begin
      if (!n_p_reset18) state <= IDLE;
      else              state <= state_next;
   end

   // Next state and per-cycle datapath strobes.
   always_comb begin
      state_next = state;
      do_load    = 1'b0;
      first_load = 1'b0;
      do_sample  = 1'b0;
      do_drive   = 1'b0;
      word_done  = 1'b0;
      end_frame  = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall) state_next = LOAD;
         end
         LOAD: begin
            do_load    = 1'b1;
            first_load = 1'b1;
            state_next = SHIFT;
         end
         SHIFT: begin
            if (sample_edge) begin
               do_sample = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  word_done = 1'b1;
                  // Reload only if the master keeps the frame open.
                  do_load   = !ss_s;
               end
            end else if (drive_edge && (cpha18 || bit_cnt != '0)) begin
               // With cpha=0 the new word's first bit is already on so18.
               do_drive = 1'b1;
            end
            if (ss_s) begin
               end_frame  = 1'b1;
               abort      = (bit_cnt != '0) && !word_done;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Transmit holding register: accept from the port, release on load.
   always_ff @(posedge pclk18 or negedge n_p_reset18) begin
      if (!n_p_reset18) begin
         hold_reg  <= '0;
         hold_full <= 1'b0;
      end else if (tx_valid18 && tx_ready18) begin
         hold_reg  <= tx_data18;
         hold_full <= 1'b1;
      end else if (do_load && hold_full) begin
         hold_full <= 1'b0;
      end
   end

   // Shift registers, bit counter and status pulses.
   always_ff @(posedge pclk18 or negedge n_p_reset18) begin
      if (!n_p_reset18) begin
         tx_sr         <= '0;
         rx_sr         <= '0;
         bit_cnt       <= '0;
         so18          <= 1'b0;
         n_so_en18     <= 1'b1;
         rx_data18     <= '0;
         rx_valid18    <= 1'b0;
         tx_underrun18 <= 1'b0;
         frame_abort18 <= 1'b0;
         underrun_pend <= 1'b0;
      end else begin
         rx_valid18    <= 1'b0;
         tx_underrun18 <= 1'b0;
         frame_abort18 <= abort;
         if (do_sample) begin
            rx_sr   <= rx_sr_next;
            bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
            if (word_done) begin
               rx_data18  <= rx_sr_next;
               rx_valid18 <= 1'b1;
            end
            // A back-to-back word that was reloaded empty only underruns once it is clocked.
            if (bit_cnt == '0 && underrun_pend) begin
               tx_underrun18 <= 1'b1;
               underrun_pend <= 1'b0;
            end
         end
         if (do_drive) begin
            so18  <= tx_out_bit;
            tx_sr <= tx_sr_shifted;
         end
         if (do_load) begin
            tx_sr     <= cpha18 ? load_word : load_shifted;
            if (!cpha18) so18 <= load_bit;
            bit_cnt   <= '0;
            n_so_en18 <= 1'b0;
            if (first_load) tx_underrun18 <= !hold_full;
            else            underrun_pend <= !hold_full;
         end
         if (end_frame) begin
            n_so_en18     <= 1'b1;
            bit_cnt       <= '0;
            rx_sr         <= '0;
            underrun_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_responder18.sv
// tb/tb_spi_slave_responder18.sv - scoreboard bench for spi_slave_responder18
module tb_spi_slave_responder18;

   localparam int HALF = 5;

   logic       pclk18 = 1'b0;
   logic       n_p_reset18;
   logic       cpol18, cpha18, sclk_in18, n_ss_in18, si18;
   logic       so18, n_so_en18;
   logic [7:0] tx_data18;
   logic       tx_valid18, tx_ready18;
   logic [7:0] rx_data18;
   logic       rx_valid18, tx_underrun18, frame_abort18;

   int checks = 0;
   int errors = 0;
   int n_underrun = 0;
   int n_abort = 0;

   logic [7:0] exp_rx[$];
   logic [7:0] exp_miso[$];

   spi_slave_responder18 #(.DW(8), .SYNC_STAGES(2)) dut (
      .pclk18(pclk18), .n_p_reset18(n_p_reset18),
      .cpol18(cpol18), .cpha18(cpha18),
      .sclk_in18(sclk_in18), .n_ss_in18(n_ss_in18), .si18(si18),
      .so18(so18), .n_so_en18(n_so_en18),
      .tx_data18(tx_data18), .tx_valid18(tx_valid18), .tx_ready18(tx_ready18),
      .rx_data18(rx_data18), .rx_valid18(rx_valid18),
      .tx_underrun18(tx_underrun18), .frame_abort18(frame_abort18)
   );

   always #5 pclk18 = ~pclk18;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge pclk18);
      #2;
   endtask

   task automatic push_tx(input logic [7:0] d);
      int i;
      for (i = 0; i < 200 && !tx_ready18; i++) step(1);
      checks++;
      if (!tx_ready18) begin
         errors++;
         $display("FAIL tx_ready_timeout actual=0 required=1");
      end
      tx_data18  = d;
      tx_valid18 = 1'b1;
      step(1);
      tx_valid18 = 1'b0;
   endtask

   // Master model: nbits bit cycles from {w0,w1}, MSB first.
   task automatic frame(input logic p, input logic h, input logic [7:0] w0, input logic [7:0] w1,
                        input int nbits, input bit raise);
      logic [15:0] stream;
      stream    = {w0, w1};
      cpol18    = p;
      cpha18    = h;
      sclk_in18 = p;
      step(4);
      n_ss_in18 = 1'b0;
      if (!h) si18 = stream[15];
      step(2 * HALF);
      for (int k = 0; k < nbits; k++) begin
         sclk_in18 = ~p;
         if (h) si18 = stream[15-k];
         step(HALF);
         sclk_in18 = p;
         if (!h && k + 1 < nbits) si18 = stream[14-k];
         step(HALF);
      end
      if (raise) n_ss_in18 = 1'b1;
   endtask

   task automatic drain(input string tag);
      step(12);
      chk({tag, "_rx_pending"}, exp_rx.size(), 0);
      chk({tag, "_miso_pending"}, exp_miso.size(), 0);
   endtask

   // Monitor: scores rx words and MISO words against the expected queues.
   logic       sclk_m = 1'b0;
   logic       so_m = 1'b0;
   int         st_n = 0;
   int         mb = 0;
   logic [7:0] mw = '0;
   logic [7:0] e;
   logic       smp;
   always @(negedge pclk18) begin
      if (!n_p_reset18) begin
         mb = 0;
      end else begin
         if (rx_valid18) begin
            if (exp_rx.size() == 0) begin
               checks++; errors++;
               $display("FAIL rx_unexpected actual=%0h required=none", rx_data18);
            end else begin
               e = exp_rx.pop_front();
               chk("rx_word", rx_data18, e);
            end
         end
         if (tx_underrun18) n_underrun++;
         if (frame_abort18) n_abort++;
         if (so18 === so_m) st_n++;
         else st_n = 0;
         so_m = so18;
         if (n_ss_in18) begin
            mb = 0;
         end else if (sclk_in18 !== sclk_m) begin
            smp = cpha18 ? (sclk_in18 == cpol18) : (sclk_in18 != cpol18);
            if (smp) begin
               chk("so_stable", (st_n >= 2), 1);
               mw = {mw[6:0], so18};
               mb++;
               if (mb == 8) begin
                  mb = 0;
                  if (exp_miso.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL miso_unexpected actual=%0h required=none", mw);
                  end else begin
                     e = exp_miso.pop_front();
                     chk("miso_word", mw, e);
                  end
               end
            end
         end
      end
      sclk_m = sclk_in18;
   end

   initial begin
      int u0, a0;
      logic [1:0] modes[3];
      modes[0] = 2'b01; modes[1] = 2'b10; modes[2] = 2'b11;

      n_p_reset18 = 1'b0;
      cpol18 = 0; cpha18 = 0; sclk_in18 = 0; n_ss_in18 = 1; si18 = 0;
      tx_data18 = '0; tx_valid18 = 0;
      step(3);
      chk("rst_so", so18, 0);
      chk("rst_n_so_en", n_so_en18, 1);
      chk("rst_tx_ready", tx_ready18, 1);
      chk("rst_rx_data", rx_data18, 0);
      chk("rst_rx_valid", rx_valid18, 0);
      chk("rst_underrun", tx_underrun18, 0);
      chk("rst_abort", frame_abort18, 0);
      n_p_reset18 = 1'b1;
      step(4);

      // Mode 0 single word.
      u0 = n_underrun;
      push_tx(8'hA5);
      chk("t1_tx_ready_low", tx_ready18, 0);
      exp_miso.push_back(8'hA5); exp_rx.push_back(8'h3C);
      frame(0, 0, 8'h3C, 8'h00, 8, 1);
      drain("t1");
      chk("t1_tx_ready_high", tx_ready18, 1);
      chk("t1_underrun", n_underrun - u0, 0);

      // Modes 1, 2, 3.
      foreach (modes[m]) begin
         push_tx(8'hA5);
         exp_miso.push_back(8'hA5); exp_rx.push_back(8'h3C);
         frame(modes[m][1], modes[m][0], 8'h3C, 8'h00, 8, 1);
         drain("t2");
      end

      // Back-to-back, second tx word supplied mid-first-word.
      u0 = n_underrun;
      push_tx(8'h11);
      exp_miso.push_back(8'h11); exp_miso.push_back(8'h22);
      exp_rx.push_back(8'h81);   exp_rx.push_back(8'h42);
      fork
         frame(0, 0, 8'h81, 8'h42, 16, 1);
         begin step(40); push_tx(8'h22); end
      join
      drain("t3");
      chk("t3_underrun", n_underrun - u0, 0);

      // Underrun.
      u0 = n_underrun;
      exp_miso.push_back(8'hFF); exp_rx.push_back(8'h00);
      frame(1, 1, 8'h00, 8'h00, 8, 1);
      drain("t4");
      chk("t4_underrun", n_underrun - u0, 1);
      chk("t4_rx_data", rx_data18, 8'h00);

      // Abort after 5 bits, then a clean frame.
      a0 = n_abort; u0 = n_underrun;
      frame(0, 0, 8'hF0, 8'h00, 5, 0);
      step(HALF);
      n_ss_in18 = 1'b1;
      begin
         bit seen;
         seen = 0;
         for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge pclk18);
            if (n_so_en18) seen = 1;
         end
         chk("t5_n_so_en_release", seen, 1);
      end
      drain("t5a");
      chk("t5_abort", n_abort - a0, 1);
      chk("t5_underrun", n_underrun - u0, 1);
      push_tx(8'hC3);
      exp_miso.push_back(8'hC3); exp_rx.push_back(8'h5A);
      frame(0, 0, 8'h5A, 8'h00, 8, 1);
      drain("t5b");
      chk("t5_no_second_abort", n_abort - a0, 1);

      // Reset mid-word.
      frame(0, 0, 8'hE7, 8'h00, 3, 0);
      push_tx(8'h99);
      chk("t6_hold_full", tx_ready18, 0);
      n_p_reset18 = 1'b0;
      #1;
      chk("t6_n_so_en", n_so_en18, 1);
      chk("t6_tx_ready", tx_ready18, 1);
      chk("t6_rx_data", rx_data18, 0);
      step(2);
      n_ss_in18 = 1'b1; sclk_in18 = 0;
      n_p_reset18 = 1'b1;
      step(5);
      push_tx(8'h96);
      exp_miso.push_back(8'h96); exp_rx.push_back(8'hE7);
      frame(0, 0, 8'hE7, 8'h00, 8, 1);
      drain("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
